// File: rtl/battleship_result_rx.sv
// Result-stream receiver: decodes core result words into shot maps, hit counters and an event FIFO.
// Optional BS_RX_PARITY_EN: enforce even parity over data_in and expose err_parity.
module battleship_result_rx #(
    parameter int unsigned BOARD      = 10,
    parameter int unsigned TOTAL_HITS = 17,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        data_ready,
    input  logic [11:0] data_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [11:0] evt_data,
    input  logic        q_player,
    input  logic [3:0]  q_row,
    input  logic [3:0]  q_col,
    output logic [1:0]  q_status,
    output logic [4:0]  hits_p0,
    output logic [4:0]  hits_p1,
    output logic        game_over,
    output logic        winner,
    output logic        err_dup,
    output logic        err_range,
    output logic        err_ovf,
`ifdef BS_RX_PARITY_EN
    output logic        err_parity,
`endif
    output logic        err_proto
);

    localparam int unsigned Cells = BOARD * BOARD;
    localparam int unsigned IdxW  = $clog2(Cells);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [4:0]      TotalHitsW = 5'(TOTAL_HITS);
    localparam logic [CntW-1:0] FullCnt    = CntW'(FIFO_DEPTH);

    localparam logic [1:0] KindMiss = 2'b00;
    localparam logic [1:0] KindHit  = 2'b01;
    localparam logic [1:0] KindSunk = 2'b10;
    localparam logic [1:0] KindEnd  = 2'b11;

    localparam logic [1:0] CellUnshot = 2'b00;
    localparam logic [1:0] CellMiss   = 2'b01;
    localparam logic [1:0] CellHit    = 2'b10;

    typedef enum logic [0:0] {StPlaying, StGameOver} state_e;

    state_e          state_q, state_d;
    logic [1:0]      map_q [2][Cells];
    logic [1:0]      map_d [2][Cells];
    logic [4:0]      hits_q [2];
    logic [4:0]      hits_d [2];
    logic            winner_q, winner_d;
    logic            err_dup_q, err_dup_d;
    logic            err_range_q, err_range_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_proto_q, err_proto_d;
    logic            err_parity_q, err_parity_d;
    logic [11:0]     mem_q [FIFO_DEPTH];
    logic [11:0]     mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      q_status_q, q_status_d;

    logic [1:0]      kind;
    logic            shooter;
    logic            target;
    logic [3:0]      row;
    logic [3:0]      col;
    logic            in_range;
    logic [IdxW-1:0] cell_idx;
    logic            q_in_range;
    logic [IdxW-1:0] q_idx;
    logic            parity_bad;
    logic            accept;
    logic            push;
    logic            pop;

    always_comb begin
        state_d      = state_q;
        map_d        = map_q;
        hits_d       = hits_q;
        winner_d     = winner_q;
        err_dup_d    = err_dup_q;
        err_range_d  = err_range_q;
        err_ovf_d    = err_ovf_q;
        err_proto_d  = err_proto_q;
        err_parity_d = err_parity_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;

        kind     = data_in[11:10];
        shooter  = data_in[9];
        target   = ~data_in[9];
        row      = data_in[7:4];
        col      = data_in[3:0];
        in_range = (32'(row) < BOARD) && (32'(col) < BOARD);
        cell_idx = in_range ? IdxW'(32'(row) * BOARD + 32'(col)) : '0;
`ifdef BS_RX_PARITY_EN
        parity_bad = ^data_in;
`else
        parity_bad = 1'b0;
`endif

        unique case (state_q)
            StPlaying: begin
                if (data_ready) begin
                    // Checks are prioritised: parity, then range, then duplicate shot.
                    if (parity_bad) begin
                        err_parity_d = 1'b1;
                    end else if (!in_range) begin
                        err_range_d = 1'b1;
                    end else if (kind != KindEnd && map_q[target][cell_idx] != CellUnshot) begin
                        err_dup_d = 1'b1;
                    end else begin
                        accept = 1'b1;
                        unique case (kind)
                            KindMiss: map_d[target][cell_idx] = CellMiss;
                            KindHit, KindSunk: begin
                                map_d[target][cell_idx] = CellHit;
                                if (hits_q[shooter] != TotalHitsW) begin
                                    hits_d[shooter] = hits_q[shooter] + 5'd1;
                                    if (hits_d[shooter] == TotalHitsW) begin
                                        state_d  = StGameOver;
                                        winner_d = shooter;
                                    end
                                end
                            end
                            KindEnd: begin
                                state_d  = StGameOver;
                                winner_d = shooter;
                            end
                        endcase
                    end
                end
            end
            StGameOver: begin
                if (data_ready) begin
                    err_proto_d = 1'b1;
                end
            end
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        pop  = evt_ready && (cnt_q != '0);
        push = accept && ((cnt_q != FullCnt) || pop);
        if (accept && !push) begin
            err_ovf_d = 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);

        q_in_range = (32'(q_row) < BOARD) && (32'(q_col) < BOARD);
        q_idx      = q_in_range ? IdxW'(32'(q_row) * BOARD + 32'(q_col)) : '0;
        q_status_d = q_in_range ? map_q[q_player][q_idx] : CellUnshot;
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q      <= StPlaying;
            map_q        <= '{default: '0};
            hits_q       <= '{default: '0};
            winner_q     <= 1'b0;
            err_dup_q    <= 1'b0;
            err_range_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_proto_q  <= 1'b0;
            err_parity_q <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            q_status_q   <= '0;
        end else begin
            state_q      <= state_d;
            map_q        <= map_d;
            hits_q       <= hits_d;
            winner_q     <= winner_d;
            err_dup_q    <= err_dup_d;
            err_range_q  <= err_range_d;
            err_ovf_q    <= err_ovf_d;
            err_proto_q  <= err_proto_d;
            err_parity_q <= err_parity_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            q_status_q   <= q_status_d;
        end
    end

    assign evt_valid = (cnt_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign q_status  = q_status_q;
    assign hits_p0   = hits_q[0];
    assign hits_p1   = hits_q[1];
    assign game_over = (state_q == StGameOver);
    assign winner    = winner_q;
    assign err_dup   = err_dup_q;
    assign err_range = err_range_q;
    assign err_ovf   = err_ovf_q;
    assign err_proto = err_proto_q;
`ifdef BS_RX_PARITY_EN
    assign err_parity = err_parity_q;
`else
    logic unused_parity;
    assign unused_parity = err_parity_q;
`endif

endmodule

// File: tb/tb_battleship_result_rx.sv
// Bench for battleship_result_rx: cell-array/queue reference model checked every cycle plus literal spot checks.
module tb_battleship_result_rx;

    localparam int Board = 10;
    localparam int Total = 17;
    localparam int Depth = 4;
`ifdef BS_RX_PARITY_EN
    localparam logic [11:0] FirstWord = 12'h535;
`else
    localparam logic [11:0] FirstWord = 12'h435;
`endif

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic        data_ready = 1'b0;
    logic [11:0] data_in = '0;
    logic        evt_ready = 1'b0;
    logic        q_player = 1'b0;
    logic [3:0]  q_row = '0;
    logic [3:0]  q_col = '0;
    logic        evt_valid;
    logic [11:0] evt_data;
    logic [1:0]  q_status;
    logic [4:0]  hits_p0;
    logic [4:0]  hits_p1;
    logic        game_over;
    logic        winner;
    logic        err_dup;
    logic        err_range;
    logic        err_ovf;
    logic        err_proto;
`ifdef BS_RX_PARITY_EN
    logic        err_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    battleship_result_rx dut (
        .ph1        (ph1),
        .reset      (reset),
        .data_ready (data_ready),
        .data_in    (data_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .q_player   (q_player),
        .q_row      (q_row),
        .q_col      (q_col),
        .q_status   (q_status),
        .hits_p0    (hits_p0),
        .hits_p1    (hits_p1),
        .game_over  (game_over),
        .winner     (winner),
        .err_dup    (err_dup),
        .err_range  (err_range),
        .err_ovf    (err_ovf),
`ifdef BS_RX_PARITY_EN
        .err_parity (err_parity),
`endif
        .err_proto  (err_proto)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] mk(input logic [1:0] k, input logic s,
                                       input logic [3:0] r, input logic [3:0] c);
        logic [11:0] w;
        w = {k, s, 1'b0, r, c};
`ifdef BS_RX_PARITY_EN
        w[8] = ^w;
`endif
        return w;
    endfunction

    // Reference model: plain cell grid, hit tallies and an event queue.
    int          m_map [2][16][16];
    int          m_hits [2];
    bit          m_over, m_win, m_dup, m_rng, m_ovf, m_proto, m_par;
    logic [1:0]  m_qs;
    logic [11:0] m_fifo [$];

    always @(posedge ph1) begin : model
        bit acc;
        bit pop;
        int tgt, r, c, k;
        acc = 1'b0;
        if (reset) begin
            foreach (m_map[p, i, j]) m_map[p][i][j] = 0;
            m_hits[0] = 0; m_hits[1] = 0;
            {m_over, m_win, m_dup, m_rng, m_ovf, m_proto, m_par} = '0;
            m_qs = 2'b00;
            m_fifo.delete();
        end else begin
            m_qs = (q_row < Board && q_col < Board) ? 2'(m_map[q_player][q_row][q_col]) : 2'b00;
            pop = evt_ready && (m_fifo.size() > 0);
            if (data_ready) begin
                k = data_in[11:10];
                tgt = data_in[9] ? 0 : 1;
                r = data_in[7:4];
                c = data_in[3:0];
                if (m_over) m_proto = 1'b1;
`ifdef BS_RX_PARITY_EN
                else if (^data_in) m_par = 1'b1;
`endif
                else if (r >= Board || c >= Board) m_rng = 1'b1;
                else if (k != 3 && m_map[tgt][r][c] != 0) m_dup = 1'b1;
                else begin
                    acc = 1'b1;
                    if (k == 0) m_map[tgt][r][c] = 1;
                    else if (k == 3) begin
                        m_over = 1'b1; m_win = data_in[9];
                    end else begin
                        m_map[tgt][r][c] = 2;
                        if (m_hits[data_in[9]] < Total) m_hits[data_in[9]]++;
                        if (m_hits[data_in[9]] == Total) begin
                            m_over = 1'b1; m_win = data_in[9];
                        end
                    end
                end
            end
            if (pop) void'(m_fifo.pop_front());
            if (acc) begin
                if (m_fifo.size() < Depth) m_fifo.push_back(data_in);
                else m_ovf = 1'b1;
            end
        end
    end

    initial begin : compare
        @(posedge ph1);
        forever begin
            @(negedge ph1);
            check("evt_valid", evt_valid, m_fifo.size() != 0);
            if (m_fifo.size() != 0) check("evt_data", evt_data, m_fifo[0]);
            check("q_status", q_status, m_qs);
            check("hits_p0", hits_p0, m_hits[0]);
            check("hits_p1", hits_p1, m_hits[1]);
            check("game_over", game_over, m_over);
            check("winner", winner, m_win);
            check("err_dup", err_dup, m_dup);
            check("err_range", err_range, m_rng);
            check("err_ovf", err_ovf, m_ovf);
            check("err_proto", err_proto, m_proto);
`ifdef BS_RX_PARITY_EN
            check("err_parity", err_parity, m_par);
`endif
        end
    end

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic send(input logic [11:0] w);
        data_ready = 1'b1;
        data_in    = w;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin : stim
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_hits_p0", hits_p0, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_game_over", game_over, 0);

        // First hit: query of the same cell sees the old value on the strobe edge.
        q_player = 1'b1; q_row = 4'd3; q_col = 4'd5;
        send(mk(2'b01, 1'b0, 4'd3, 4'd5));
        check("hit1_hits_p0", hits_p0, 1);
        check("hit1_evt_valid", evt_valid, 1);
        check("hit1_evt_data", evt_data, FirstWord);
        check("hit1_q_old", q_status, 2'b00);
        tick();
        check("hit1_q_new", q_status, 2'b10);

        send(mk(2'b01, 1'b0, 4'd3, 4'd5));
        check("dup_flag", err_dup, 1);
        check("dup_hits_p0", hits_p0, 1);

        q_row = 4'd10; q_col = 4'd2;
        send(mk(2'b00, 1'b0, 4'd10, 4'd2));
        check("range_flag", err_range, 1);
        check("range_head", evt_data, FirstWord);
        tick();
        check("range_query", q_status, 2'b00);

        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("drain1_empty", evt_valid, 0);

        // Fill four, then push into a full FIFO while popping: no overflow.
        for (int c = 0; c < 4; c++) send(mk(2'b00, 1'b0, 4'd1, 4'(c)));
        evt_ready = 1'b1;
        send(mk(2'b00, 1'b0, 4'd1, 4'd4));
        evt_ready = 1'b0;
        check("full_pushpop_noovf", err_ovf, 0);
        q_row = 4'd1; q_col = 4'd5;
        send(mk(2'b00, 1'b0, 4'd1, 4'd5));
        check("ovf_flag", err_ovf, 1);
        tick();
        check("ovf_map_updated", q_status, 2'b01);
        evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", evt_data, mk(2'b00, 1'b0, 4'd1, 4'(i)));
            tick();
        end
        check("drain2_empty", evt_valid, 0);
        evt_ready = 1'b0;

        do_reset();
        send(mk(2'b11, 1'b0, 4'd2, 4'd2));
        check("end_game_over", game_over, 1);
        check("end_winner", winner, 0);

        // Reset mid-game with an event mid-handshake.
        evt_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        evt_ready = 1'b0;
        check("midrst_evt_valid", evt_valid, 0);
        check("midrst_game_over", game_over, 0);
        check("midrst_err_dup", err_dup, 0);

        // Player 1 sinks everything; player 0 lands a few sunk reports on the way.
        evt_ready = 1'b1;
        q_player = 1'b0; q_row = 4'd0; q_col = 4'd7;
        for (int i = 0; i < Total - 1; i++) begin
            send(mk(2'b01, 1'b1, 4'(i / 10), 4'(i % 10)));
            if (i < 3) send(mk(2'b10, 1'b0, 4'(i + 4), 4'(i)));
        end
        check("p1_16_hits", hits_p1, 16);
        check("p1_16_not_over", game_over, 0);
        check("p1_16_q", q_status, 2'b10);
        send(mk(2'b01, 1'b1, 4'd9, 4'd9));
        check("p1_17_hits", hits_p1, 17);
        check("p1_17_over", game_over, 1);
        check("p1_17_winner", winner, 1);
        send(mk(2'b00, 1'b0, 4'd5, 4'd5));
        check("proto_flag", err_proto, 1);
        check("proto_hits_p0", hits_p0, 3);
        q_row = 4'd12;
        tick();
        tick();
        check("oor_query", q_status, 2'b00);
        evt_ready = 1'b0;

`ifdef BS_RX_PARITY_EN
        do_reset();
        send(12'h001);
        check("parity_flag", err_parity, 1);
        check("parity_dropped", evt_valid, 0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
